// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the skid-buffered pipeline register: state encoding
// and the state-to-occupancy decode.
package pipe_skid_reg_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // The unreachable encoding reports zero words, matching its recovery target.
  function automatic logic [OCC_W-1:0] occupancy_of(input skid_state_e st);
    case (st)
      ST_BUSY: occupancy_of = 2'd1;
      ST_FULL: occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_register.sv
// Enabled N-bit register with asynchronous active-low reset to a fixed value.
module Register #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= RESET_VALUE;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: main register feeds the consumer, skid register
// catches the word accepted while the consumer stalls.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic [OCC_W-1:0]       occupancy
);

  // Handshake: a word moves on a rising edge where valid and ready are both
  // high; ready/valid here are decoded from registered state only.
  skid_state_e state_q, state_d;

  logic                   in_xfer, out_xfer;
  logic                   main_en, skid_en, main_from_skid;
  logic [WORD_LENGTH-1:0] main_d, skid_q;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = occupancy_of(state_q);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Data registers keep their contents; only the word count is dropped.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_en = 1'b1;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_en = 1'b1;
          end else if (in_xfer) begin
            skid_en = 1'b1;
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  Register #(
    .WIDTH       (WORD_LENGTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  Register #(
    .WIDTH       (WORD_LENGTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue model of held words checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_skid_reg;

  localparam int         W  = 32;
  localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_pass;
  logic         cmp_en;

  pipe_skid_reg #(
    .WORD_LENGTH (W),
    .RESET_VALUE (RV)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of at most two words; consumer takes the head, producer
  // appends when fewer than two are held; flush/reset empty it.
  logic m_in, m_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      m_in  = in_valid && (exp_q.size() < 2);
      m_out = out_ready && (exp_q.size() > 0);
      if (m_out) void'(exp_q.pop_front());
      if (m_in) exp_q.push_back(in_data);
    end
  end

  // compare process
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      check("occupancy", 32'(occupancy), 32'(exp_q.size()));
      if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
      if (occupancy == 2'd2) check("ready_when_full", 32'(in_ready), 32'd0);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  logic [W-1:0] words[3];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cmp_en   = 1'b1;
    rst_n    = 1'b0;
    drive(1'b1, 32'h99, 1'b1, 1'b0);

    // reset held with input offered and clock running
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_out_data", out_data, RV);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step();

    // streaming, one word per cycle
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, words[i], 1'b1, 1'b0);
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", out_data, words[i]);
      check("stream_occ", 32'(occupancy), 32'd1);
      check("stream_model", exp_q[0], words[i]);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("stream_drain_occ", 32'(occupancy), 32'd0);

    // backpressure
    drive(1'b1, 32'hA0, 1'b0, 1'b0);
    step();
    check("bp_occ1", 32'(occupancy), 32'd1);
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    step();
    check("bp_occ2", 32'(occupancy), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", out_data, 32'hA0);
    drive(1'b1, 32'hEE, 1'b0, 1'b0);
    step();
    check("bp_hold_occ", 32'(occupancy), 32'd2);
    check("bp_hold_data", out_data, 32'hA0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("bp_second", out_data, 32'hA1);
    check("bp_occ_after", 32'(occupancy), 32'd1);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // flush while full, with a word offered
    drive(1'b1, 32'hB0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hB1, 1'b0, 1'b0); step();
    check("fl_full", 32'(occupancy), 32'd2);
    drive(1'b1, 32'h55, 1'b0, 1'b1);
    step();
    check("fl_occ", 32'(occupancy), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) begin
      step();
      check("fl_no_55", 32'(out_valid), 32'd0);
    end

    // flush while one word held, input and output both active
    drive(1'b1, 32'hC0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h56, 1'b1, 1'b1);
    step();
    check("fl_busy_occ", 32'(occupancy), 32'd0);
    check("fl_keep_data", out_data, 32'hC0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("fl_busy_idle", 32'(out_valid), 32'd0);

    // asynchronous reset between edges while full
    drive(1'b1, 32'hD0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hD1, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("ar_full", 32'(occupancy), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_occ", 32'(occupancy), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_data", out_data, RV);
    step();
    rst_n = 1'b1;
    drive(1'b1, 32'h77, 1'b1, 1'b0);
    step();
    check("ar_77_valid", 32'(out_valid), 32'd1);
    check("ar_77_data", out_data, 32'h77);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();

    // random traffic, occasional flush
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) step();
    check("final_empty", 32'(occupancy), 32'd0);

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32: width of the data path in bits.
REQ-002 SHALL have parameter RESET_VALUE, default 0: value loaded into both data registers on reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held words.
REQ-006 SHALL have port in_valid  input  1  producer presents a word.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port in_data  input  WORD_LENGTH  producer word.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word this cycle.
REQ-011 SHALL have port out_data  output  WORD_LENGTH  word presented to the consumer.
REQ-012 SHALL have port occupancy  output  2  number of held words, 0..2.

Function
REQ-013 SHALL define a transfer as valid&&ready sampled high on the same rising edge, on either side.
REQ-014 SHALL hold up to two words: main register (drives out_data) and skid register.
REQ-015 SHALL implement states EMPTY (0 words), BUSY (main only), FULL (main+skid); occupancy = 0/1/2.
REQ-016 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-017 EMPTY: input transfer -> main<=in_data, go BUSY; otherwise stay.
REQ-018 BUSY: input and output transfer -> main<=in_data, stay BUSY; input only -> skid<=in_data, go FULL; output only -> go EMPTY; neither -> hold.
REQ-019 FULL: output transfer -> main<=skid, go BUSY; otherwise hold; no input transfer is possible.
REQ-020 SHALL give a latency of 1 cycle from input transfer to out_valid in EMPTY, and sustain 1 word/cycle when out_ready is held high.
REQ-021 SHALL preserve word order; no word is duplicated or dropped except by flush or reset.
REQ-022 flush SHALL take priority over all transfers: next state EMPTY; the in_data word of that cycle is discarded even if in_valid and in_ready are high.
REQ-023 Data registers SHALL keep their contents on flush; only the state changes.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 in_data SHALL be ignored when no input transfer occurs.

Reset
REQ-026 While reset=0, SHALL force state EMPTY, both data registers to RESET_VALUE, out_valid=0, in_ready=1, occupancy=0, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard all held words immediately; the first edge after release SHALL behave as EMPTY.

Structure
REQ-028 SHALL place the 2-bit state encoding (EMPTY=0, BUSY=1, FULL=2) in the shared pipeline package.
REQ-029 SHALL build the main and skid data storage from the existing enabled N-bit register module (Register), two instances; state logic stays in pipe_skid_reg.
REQ-030 SHALL treat state value 3 as unreachable and recover to EMPTY on the next edge.

Verification
REQ-031 Reset: hold reset=0 with in_valid=1 and clock running -> out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE.
REQ-032 Streaming: out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the following consecutive cycles, occupancy stays 1.
REQ-033 Backpressure: out_ready=0, send 0xA0 then 0xA1 -> occupancy 2 and in_ready=0; raise out_ready -> 0xA0 then 0xA1 delivered, in order.
REQ-034 Flush with input: state FULL, assert flush together with in_valid=1 and in_data=0x55 -> next cycle occupancy=0, out_valid=0; 0x55 is never output.
REQ-035 Async reset mid-stream: occupancy 2, pull reset low between edges -> out_valid falls without waiting for a clk edge; after release, 0x77 sent -> 0x77 output after 1 cycle.
REQ-036 Random: random in_valid/out_ready at 50% for 10k cycles against a reference queue -> order matches, zero losses, in_ready never 1 while occupancy=2.
